// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller: arbitrates the MEM data port over the IF fetch port
// and turns each captured request into single-byte accesses on a synchronous 8-bit RAM.
module mem_ctrl #(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dm_ce_i,
    input  logic              dm_we_i,
    input  logic [31:0]       dm_addr_i,
    input  logic [3:0]        dm_sel_i,
    input  logic [31:0]       dm_data_i,
    output logic [31:0]       dm_data_o,
    output logic              dm_busy_o,
    output logic              dm_done_o,
    input  logic              if_ce_i,
    input  logic [31:0]       if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_busy_o,
    output logic              if_done_o,
    output logic [RAM_AW-1:0] ram_a_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    localparam logic PDM = 1'b0;
    localparam logic PIF = 1'b1;

    state_t state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic        srv_q, srv_d;
    logic        dm_full_q, dm_full_d, dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
    logic [3:0]  dm_sel_q, dm_sel_d;
    logic        if_full_q, if_full_d;
    logic [31:0] if_addr_q, if_addr_d;
    logic [31:0] rd_buf_q, rd_buf_d;
    logic [31:0] dm_data_q, dm_data_d, if_data_q, if_data_d;
    logic        dm_busy_q, dm_busy_d, dm_done_q, dm_done_d;
    logic        if_busy_q, if_busy_d, if_done_q, if_done_d;
    logic [RAM_AW-1:0] ram_a_q, ram_a_d;
    logic        ram_wr_q, ram_wr_d;
    logic [7:0]  ram_dout_q, ram_dout_d;

    logic        start, pick, p_we, s_we;
    logic [2:0]  p_n, s_n;
    logic [31:0] p_addr, p_data, s_addr, s_data, a_nxt;
    logic [1:0]  kb, kc;

    // Transfer length in bytes; 0 marks an unsupported size.
    function automatic logic [2:0] sel_n(input logic [3:0] s);
        case (s)
            4'b0001: sel_n = 3'd1;
            4'b0010: sel_n = 3'd2;
            4'b0100: sel_n = 3'd4;
            default: sel_n = 3'd0;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        srv_d      = srv_q;
        dm_full_d  = dm_full_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_sel_d   = dm_sel_q;
        dm_wdata_d = dm_wdata_q;
        if_full_d  = if_full_q;
        if_addr_d  = if_addr_q;
        rd_buf_d   = rd_buf_q;
        dm_data_d  = dm_data_q;
        if_data_d  = if_data_q;
        dm_done_d  = 1'b0;
        if_done_d  = 1'b0;
        ram_a_d    = ram_a_q;
        ram_wr_d   = 1'b0;
        ram_dout_d = ram_dout_q;
        start      = 1'b0;
        pick       = PDM;
        p_we       = 1'b0;
        p_n        = 3'd0;
        p_addr     = 32'd0;
        p_data     = 32'd0;

        // Served slot frees as DONE ends; a port cannot refill while its done_o is high.
        if (state_q == DONE && srv_q == PDM) dm_full_d = 1'b0;
        if (state_q == DONE && srv_q == PIF) if_full_d = 1'b0;
        if (dm_ce_i && !dm_full_q && !dm_done_q) begin
            dm_full_d  = 1'b1;
            dm_we_d    = dm_we_i;
            dm_addr_d  = dm_addr_i;
            dm_sel_d   = dm_sel_i;
            dm_wdata_d = dm_data_i;
        end
        if (if_ce_i && !if_full_q && !if_done_q) begin
            if_full_d = 1'b1;
            if_addr_d = if_addr_i;
        end

        s_addr = (srv_q == PIF) ? if_addr_q : dm_addr_q;
        s_data = dm_wdata_q;
        s_we   = (srv_q == PIF) ? 1'b0 : dm_we_q;
        s_n    = (srv_q == PIF) ? 3'd4 : sel_n(dm_sel_q);
        kb     = k_q[1:0] + 2'd1;
        kc     = k_q[1:0] - 2'd1;
        a_nxt  = s_addr + {30'd0, kb};

        case (state_q)
            IDLE: begin
                if (dm_full_q) begin
                    start = 1'b1;
                    pick  = PDM;
                end else if (if_full_q) begin
                    start = 1'b1;
                    pick  = PIF;
                end
            end
            RD: begin
                k_d = k_q + 3'd1;
                if (k_q != 3'd0) rd_buf_d[8*kc +: 8] = ram_din_i;
                if (k_q + 3'd1 < s_n) ram_a_d = a_nxt[RAM_AW-1:0];
                if (k_q == s_n) begin
                    state_d = DONE;
                    if (srv_q == PDM) begin
                        dm_data_d = rd_buf_d;
                        dm_done_d = 1'b1;
                    end else begin
                        if_data_d = rd_buf_d;
                        if_done_d = 1'b1;
                    end
                end
            end
            WR: begin
                if (k_q + 3'd1 == s_n) begin
                    state_d   = DONE;
                    dm_done_d = 1'b1;
                end else begin
                    k_d        = k_q + 3'd1;
                    ram_a_d    = a_nxt[RAM_AW-1:0];
                    ram_dout_d = s_data[8*kb +: 8];
                    ram_wr_d   = s_we;
                end
            end
            DONE: begin
                if (srv_q == PDM && if_full_q) begin
                    start = 1'b1;
                    pick  = PIF;
                end else if (srv_q == PIF && dm_full_q) begin
                    start = 1'b1;
                    pick  = PDM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            p_addr = (pick == PIF) ? if_addr_q : dm_addr_q;
            p_data = dm_wdata_q;
            p_we   = (pick == PIF) ? 1'b0 : dm_we_q;
            p_n    = (pick == PIF) ? 3'd4 : sel_n(dm_sel_q);
            srv_d  = pick;
            k_d    = 3'd0;
            if (p_n == 3'd0) begin
                state_d   = DONE;
                dm_done_d = 1'b1;
                dm_data_d = 32'd0;
            end else begin
                ram_a_d = p_addr[RAM_AW-1:0];
                if (p_we) begin
                    state_d    = WR;
                    ram_wr_d   = 1'b1;
                    ram_dout_d = p_data[7:0];
                end else begin
                    state_d  = RD;
                    rd_buf_d = 32'd0;
                end
            end
        end

        // Busy trails slot fill by one cycle and drops as done rises.
        dm_busy_d = dm_full_q & dm_full_d & ~dm_done_d;
        if_busy_d = if_full_q & if_full_d & ~if_done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= 3'd0;
            srv_q      <= PDM;
            dm_full_q  <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= 32'd0;
            dm_sel_q   <= 4'd0;
            dm_wdata_q <= 32'd0;
            if_full_q  <= 1'b0;
            if_addr_q  <= 32'd0;
            rd_buf_q   <= 32'd0;
            dm_data_q  <= 32'd0;
            if_data_q  <= 32'd0;
            dm_busy_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_busy_q  <= 1'b0;
            if_done_q  <= 1'b0;
            ram_a_q    <= '0;
            ram_wr_q   <= 1'b0;
            ram_dout_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            srv_q      <= srv_d;
            dm_full_q  <= dm_full_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_sel_q   <= dm_sel_d;
            dm_wdata_q <= dm_wdata_d;
            if_full_q  <= if_full_d;
            if_addr_q  <= if_addr_d;
            rd_buf_q   <= rd_buf_d;
            dm_data_q  <= dm_data_d;
            if_data_q  <= if_data_d;
            dm_busy_q  <= dm_busy_d;
            dm_done_q  <= dm_done_d;
            if_busy_q  <= if_busy_d;
            if_done_q  <= if_done_d;
            ram_a_q    <= ram_a_d;
            ram_wr_q   <= ram_wr_d;
            ram_dout_q <= ram_dout_d;
        end
    end

    assign dm_data_o  = dm_data_q;
    assign dm_busy_o  = dm_busy_q;
    assign dm_done_o  = dm_done_q;
    assign if_data_o  = if_data_q;
    assign if_busy_o  = if_busy_q;
    assign if_done_o  = if_done_q;
    assign ram_a_o    = ram_a_q;
    assign ram_wr_o   = ram_wr_q;
    assign ram_dout_o = ram_dout_q;

endmodule
